// File: rtl/imem_loader_if.sv
// Byte-link and instruction-memory write-port bundle for imem_loader.
// The loader uses the slave view (consumes bytes, drives the write port); the host/bench uses master.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Frame loader: 16-bit big-endian word count, then big-endian 32-bit words written to imem from addr 0.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the core is released.
module imem_loader #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start_i,
    imem_loader_if.slave        bus,
    output logic                cpu_reset_o,
    output logic                cpu_enable_o,
    output logic                load_done_o,
    output logic                load_error_o,
    output logic [15:0]         word_count_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM, S_RELEASE, S_RUN, S_ERROR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER = S_CSUM;
`else
    localparam state_t S_AFTER = S_RELEASE;
`endif
    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [15:0]       words_rx_q, words_rx_d;
    logic [15:0]       word_count_q, word_count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        rx_ready;
    logic        xfer;
    logic [15:0] n_hdr;

    // In DATA, stop accepting once all N words are assembled; the final write may still be in flight.
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_HDR_HI, S_HDR_LO, S_CSUM: rx_ready = 1'b1;
            S_DATA:                     rx_ready = (words_rx_q != cnt_q);
            default:                    rx_ready = 1'b0;
        endcase
    end

    assign xfer  = bus.rx_valid & rx_ready;
    assign n_hdr = {cnt_hi_q, bus.rx_data};

    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        cnt_d        = cnt_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        words_rx_d   = words_rx_q;
        word_count_d = we_q ? word_count_q + 16'd1 : word_count_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = xfer ? (csum_q ^ bus.rx_data) : csum_q;
`endif
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (load_start_i) begin
                    state_d      = S_HDR_HI;
                    word_count_d = '0;
                    byte_idx_d   = '0;
                    words_rx_d   = '0;
                    addr_d       = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d       = '0;
`endif
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    cnt_hi_d = bus.rx_data;
                    state_d  = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    cnt_d = n_hdr;
                    if ({1'b0, n_hdr} > DEPTH_L) state_d = S_ERROR;
                    else if (n_hdr == 16'd0)     state_d = S_AFTER;
                    else                         state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = {asm_q, bus.rx_data};
                        addr_d     = ADDR_W'({words_rx_q, 2'b00});
                        words_rx_d = words_rx_q + 16'd1;
                    end else begin
                        asm_d = {asm_q[15:0], bus.rx_data};
                    end
                end
                if (we_q && (word_count_q + 16'd1 == cnt_q)) state_d = S_AFTER;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) state_d = (bus.rx_data == csum_q) ? S_RELEASE : S_ERROR;
            end
`endif
            S_RELEASE: state_d = S_RUN;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_hi_q     <= '0;
            cnt_q        <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            words_rx_q   <= '0;
            word_count_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            cnt_q        <= cnt_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            words_rx_q   <= words_rx_d;
            word_count_q <= word_count_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign bus.rx_ready   = rx_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_reset_o    = !((state_q == S_RELEASE) || (state_q == S_RUN));
    assign cpu_enable_o   = (state_q == S_RUN);
    assign load_done_o    = (state_q == S_RUN);
    assign load_error_o   = (state_q == S_ERROR);
    assign word_count_o   = word_count_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built from random/fixed payloads, expected writes queued
// by the driver and checked by an independent monitor. Honours LOADER_CHECKSUM_EN like the design.
module tb_imem_loader;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        cpu_reset, cpu_enable, load_done, load_error;
    logic [15:0] word_count;

    imem_loader_if #(.ADDR_W(32)) bus ();

    imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start_i (load_start),
        .bus          (bus),
        .cpu_reset_o  (cpu_reset),
        .cpu_enable_o (cpu_enable),
        .load_done_o  (load_done),
        .load_error_o (load_error),
        .word_count_o (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] pay[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: every write strobe must match the next queued expectation, including its cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr_data", {bus.imem_addr, bus.imem_wdata}, {mon_e.addr, mon_e.data});
                chk("write_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_timeout: byte 0x%0h not accepted, expected rx_ready within 200 cycles", b);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
        @(negedge clk);
        chk("start_ctrl", {cpu_reset, cpu_enable, load_done, load_error, bus.rx_ready}, 5'b10001);
        chk("start_word_count", 64'(word_count), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Builds the frame for n words from pay[], drives up to 'limit' bytes, queues expected writes
    // and checks the final outcome (RUN or ERROR) when the whole frame was sent.
    task automatic run_load(input int n, input bit corrupt, input int limit, input bit gaps);
        logic [7:0] fb[$];
        bit         ok;
        bit         err;
        int         w;
        int         exp_w;
        $display("load n=%0d corrupt=%0b limit=%0d gaps=%0b", n, corrupt, limit, gaps);
        fb.push_back(8'(n >> 8));
        fb.push_back(8'(n));
        if (n <= DEPTH) for (int i = 0; i < 4 * n; i++) fb.push_back(pay[i]);
`ifdef LOADER_CHECKSUM_EN
        if (n <= DEPTH) begin
            logic [7:0] x;
            x = 8'h00;
            foreach (fb[k]) x ^= fb[k];
            fb.push_back(corrupt ? (x ^ 8'h01) : x);
        end
`endif
        pulse_start();
        for (int i = 0; i < fb.size() && i < limit; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_byte(fb[i], ok);
            if (!ok) return;
            if (n <= DEPTH && i >= 2 && i < 2 + 4 * n && (i - 2) % 4 == 3)
                exp_q.push_back('{addr: 32'((i - 2) / 4 * 4),
                                  data: {fb[i-3], fb[i-2], fb[i-1], fb[i]},
                                  cyc:  cyc});
        end
        if (limit < fb.size()) return;

        err = (n > DEPTH);
`ifdef LOADER_CHECKSUM_EN
        err = err | corrupt;
        exp_w = 1;
`else
        exp_w = (n > 0) ? 2 : 1;
`endif
        if (err) begin
            @(negedge clk);
            chk("error_ctrl", {cpu_reset, cpu_enable, load_done, load_error, bus.rx_ready}, 5'b10010);
            chk("error_word_count", 64'(word_count), (n > DEPTH) ? 64'd0 : 64'(n));
        end else begin
            w = 0;
            for (int t = 1; t <= 20; t++) begin
                @(negedge clk);
                if (cpu_reset === 1'b0) begin
                    w = t;
                    break;
                end
            end
            chk("release_latency", 64'(w), 64'(exp_w));
            chk("release_enable", {63'd0, cpu_enable}, 64'd0);
            @(negedge clk);
            chk("run_ctrl", {cpu_reset, cpu_enable, load_done, load_error, bus.rx_ready}, 5'b01100);
            chk("run_word_count", 64'(word_count), 64'(n));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {bus.rx_ready, bus.imem_we, cpu_reset, cpu_enable, load_done, load_error},
            6'b001000);
        chk("reset_addr", 64'(bus.imem_addr), 64'd0);
        chk("reset_wdata", 64'(bus.imem_wdata), 64'd0);
        chk("reset_word_count", 64'(word_count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Two-word program.
        pay = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07};
        run_load(2, 1'b0, 1000, 1'b0);

        // Oversized header: 0x41 words.
        run_load(65, 1'b0, 1000, 1'b0);

        // Back-to-back payload bytes, no gaps.
        pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load(2, 1'b0, 1000, 1'b0);

        // Reset after 6 of 8 payload bytes: only word 0 written, then a clean reload.
        run_load(2, 1'b0, 8, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_ctrl", {bus.rx_ready, bus.imem_we, cpu_reset, cpu_enable, load_done, load_error},
            6'b001000);
        chk("async_reset_word_count", 64'(word_count), 64'd0);
        chk("async_reset_addr_data", {bus.imem_addr, bus.imem_wdata}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_load(2, 1'b0, 1000, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(1, 1'b0, 1000, 1'b0);
        run_load(1, 1'b1, 1000, 1'b0);
`endif

        // Reload of a running core with an empty program.
        run_load(0, 1'b0, 1000, 1'b0);

        // Randomised frames with random handshake gaps.
        for (int f = 0; f < 14; f++) begin
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(65, 300)) : int'($urandom_range(0, 6));
            pay.delete();
            for (int i = 0; i < 4 * n && n <= DEPTH; i++) pay.push_back(8'($urandom));
            run_load(n, ($urandom_range(0, 2) == 0), 1000, 1'b1);
        end

        // Full-depth load reaches the highest word address.
        pay.delete();
        for (int i = 0; i < 4 * DEPTH; i++) pay.push_back(8'($urandom));
        run_load(DEPTH, 1'b0, 100000, 1'b0);

        repeat (3) @(posedge clk);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
